// File: rtl/adder_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
// Imported by the interface, the slice and the controller.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ser_state_t;

    localparam int ADDER_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/bit_serial_adder_ctrl_if.sv
// Operand/result handshake bundle between a requester/consumer (master)
// and the bit-serial adder controller (slave).
interface bit_serial_adder_ctrl_if
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEFAULT
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             busy;

    modport master (
        output in_valid, op_a, op_b, carry_in, out_ready,
        input  in_ready, out_valid, sum, carry_out, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, carry_in, out_ready,
        output in_ready, out_valid, sum, carry_out, busy
    );
endinterface

// File: rtl/full_adder_slice.sv
// Single-bit full adder, purely combinational; reused once per clock
// by the serial controller.
module full_adder_slice (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder slice walks a WIDTH-bit operand
// pair LSB first, with valid/ready handshakes on both the operand and result side.
module bit_serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
    input logic                    clk,
    input logic                    rst,
    bit_serial_adder_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    ser_state_t       state_r;
    ser_state_t       state_next_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] sum_sh_r;
    logic [WIDTH-1:0] sum_shift_s;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             carry_out_r;
    logic [CNT_W-1:0] cnt_r;
    logic             last_bit_s;
    logic             slice_sum_s;
    logic             slice_cout_s;

    full_adder_slice u_slice (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .cin  (carry_r),
        .s    (slice_sum_s),
        .cout (slice_cout_s)
    );

    assign last_bit_s = (cnt_r == CNT_W'(WIDTH - 1));

    // Sum accumulator after this edge: slice output enters at the MSB.
    always_comb begin
        sum_shift_s            = sum_sh_r >> 1;
        sum_shift_s[WIDTH-1]   = slice_sum_s;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; operands are only considered while IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) state_next_s = RUN;
                else              state_next_s = IDLE;
            end
            RUN: begin
                if (last_bit_s) state_next_s = DONE;
                else            state_next_s = RUN;
            end
            DONE: begin
                if (bus.out_ready) state_next_s = IDLE;
                else               state_next_s = DONE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Datapath: capture on accept, shift one bit per RUN edge, publish on the last bit.
    // The published sum is a separate register so it stays stable while the next op runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_r      <= {WIDTH{1'b0}};
            b_sh_r      <= {WIDTH{1'b0}};
            sum_sh_r    <= {WIDTH{1'b0}};
            sum_r       <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            carry_out_r <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh_r   <= bus.op_a;
                        b_sh_r   <= bus.op_b;
                        carry_r  <= bus.carry_in;
                        sum_sh_r <= {WIDTH{1'b0}};
                        cnt_r    <= {CNT_W{1'b0}};
                    end
                end
                RUN: begin
                    a_sh_r   <= a_sh_r >> 1;
                    b_sh_r   <= b_sh_r >> 1;
                    sum_sh_r <= sum_shift_s;
                    carry_r  <= slice_cout_s;
                    cnt_r    <= cnt_r + CNT_W'(1);
                    if (last_bit_s) begin
                        sum_r       <= sum_shift_s;
                        carry_out_r <= slice_cout_s;
                    end
                end
                DONE: begin
                    sum_r <= sum_r;
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = (state_r == DONE);
    assign bus.busy      = (state_r == RUN) || (state_r == DONE);
    assign bus.sum       = sum_r;
    assign bus.carry_out = carry_out_r;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Self-checking bench for bit_serial_adder_ctrl: directed table, multi-cycle
// corner sequences and random operations against an arithmetic reference.
module tb_bit_serial_adder_ctrl;
    import adder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    bit_serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
    bit_serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

    bit_serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    bit_serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        int         hold;
        logic [7:0] exp_sum;
        logic       exp_co;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for out_valid on the 8-bit DUT; returns cycles waited and in_ready-low samples.
    task automatic wait_valid8(output int lat, inout int ir_low);
        lat = 0;
        while (!bus8.out_valid && lat < 50) begin
            tick();
            lat++;
            if (!bus8.in_ready) ir_low++;
        end
    endtask

    // One full operation on the 8-bit DUT; must be called with the DUT in IDLE.
    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input int hold, output logic [7:0] s_o, output logic co_o);
        int lat;
        int ir_low;
        bus8.in_valid  = 1'b1;
        bus8.op_a      = a;
        bus8.op_b      = b;
        bus8.carry_in  = cin;
        bus8.out_ready = (hold == 0);
        tick();
        bus8.in_valid = 1'b0;
        bus8.op_a     = 8'($urandom);
        bus8.op_b     = 8'($urandom);
        bus8.carry_in = 1'($urandom);
        ir_low = bus8.in_ready ? 0 : 1;
        wait_valid8(lat, ir_low);
        chk("latency", 64'(lat), 64'd8);
        s_o  = bus8.sum;
        co_o = bus8.carry_out;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (!bus8.in_ready) ir_low++;
            chk("hold_valid", 64'(bus8.out_valid), 64'd1);
            chk("hold_sum", 64'(bus8.sum), 64'(s_o));
            chk("hold_co", 64'(bus8.carry_out), 64'(co_o));
        end
        bus8.out_ready = 1'b1;
        tick();
        chk("valid_drop", 64'(bus8.out_valid), 64'd0);
        chk("in_ready_back", 64'(bus8.in_ready), 64'd1);
        chk("in_ready_low_cycles", 64'(ir_low), 64'(9 + hold));
    endtask

    initial begin
        logic [7:0] s;
        logic       co;
        logic [8:0] ref_full;
        int         lat;
        int         irl;

        tbl[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, hold: 0, exp_sum: 8'h10, exp_co: 1'b0};
        tbl[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, hold: 0, exp_sum: 8'h00, exp_co: 1'b1};
        tbl[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, hold: 0, exp_sum: 8'hFF, exp_co: 1'b1};
        tbl[3] = '{a: 8'h00, b: 8'h00, cin: 1'b0, hold: 0, exp_sum: 8'h00, exp_co: 1'b0};
        tbl[4] = '{a: 8'hA5, b: 8'h5A, cin: 1'b0, hold: 5, exp_sum: 8'hFF, exp_co: 1'b0};
        tbl[5] = '{a: 8'h80, b: 8'h80, cin: 1'b1, hold: 1, exp_sum: 8'h01, exp_co: 1'b1};

        bus8.in_valid = 1'b0; bus8.op_a = 8'h00; bus8.op_b = 8'h00;
        bus8.carry_in = 1'b0; bus8.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.op_a = 1'b0; bus1.op_b = 1'b0;
        bus1.carry_in = 1'b0; bus1.out_ready = 1'b0;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", 64'(bus8.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus8.out_valid), 64'd0);
        chk("rst_sum", 64'(bus8.sum), 64'd0);
        chk("rst_co", 64'(bus8.carry_out), 64'd0);
        chk("rst_busy", 64'(bus8.busy), 64'd0);

        // Directed table.
        for (int i = 0; i < 6; i++) begin
            do_op8(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].hold, s, co);
            chk($sformatf("tbl%0d_sum", i), 64'(s), 64'(tbl[i].exp_sum));
            chk($sformatf("tbl%0d_co", i), 64'(co), 64'(tbl[i].exp_co));
        end

        // in_valid held high with changing operands during RUN.
        bus8.out_ready = 1'b0;
        bus8.in_valid  = 1'b1;
        bus8.op_a = 8'h12; bus8.op_b = 8'h34; bus8.carry_in = 1'b0;
        tick();
        lat = 0;
        while (!bus8.out_valid && lat < 50) begin
            bus8.op_a = 8'($urandom);
            bus8.op_b = 8'($urandom);
            bus8.carry_in = 1'($urandom);
            chk("run_ignores_in_ready", 64'(bus8.in_ready), 64'd0);
            tick();
            lat++;
        end
        chk("run_ignore_lat", 64'(lat), 64'd8);
        chk("run_ignore_sum", 64'(bus8.sum), 64'h46);
        // in_valid and out_ready together in DONE: only the handshake acts.
        bus8.op_a = 8'h01; bus8.op_b = 8'h02; bus8.carry_in = 1'b0;
        bus8.out_ready = 1'b1;
        tick();
        chk("done_both_idle", 64'(bus8.busy), 64'd0);
        chk("done_both_ready", 64'(bus8.in_ready), 64'd1);
        tick();
        bus8.in_valid = 1'b0;
        chk("next_accept_busy", 64'(bus8.busy), 64'd1);
        irl = 0;
        wait_valid8(lat, irl);
        chk("next_accept_lat", 64'(lat), 64'd8);
        chk("next_accept_sum", 64'(bus8.sum), 64'h03);
        tick();

        // Reset during the 4th RUN cycle abandons the operation.
        bus8.out_ready = 1'b1;
        bus8.in_valid = 1'b1;
        bus8.op_a = 8'h77; bus8.op_b = 8'h11; bus8.carry_in = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        tick(); tick(); tick();
        chk("pre_rst_busy", 64'(bus8.busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_in_ready", 64'(bus8.in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(bus8.out_valid), 64'd0);
        chk("mid_rst_sum", 64'(bus8.sum), 64'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("mid_rst_no_valid", 64'(bus8.out_valid), 64'd0);
        end
        do_op8(8'h01, 8'h01, 1'b0, 0, s, co);
        chk("post_rst_sum", 64'(s), 64'h02);
        chk("post_rst_co", 64'(co), 64'd0);

        // Random operations against a plain arithmetic reference.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rc;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            ref_full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            do_op8(ra, rb, rc, int'($urandom_range(0, 2)), s, co);
            chk("rand_sum", 64'(s), 64'(ref_full[7:0]));
            chk("rand_co", 64'(co), 64'(ref_full[8]));
        end

        // WIDTH=1 instance: 1+1+1.
        bus1.in_valid = 1'b1;
        bus1.op_a = 1'b1; bus1.op_b = 1'b1; bus1.carry_in = 1'b1;
        bus1.out_ready = 1'b0;
        tick();
        bus1.in_valid = 1'b0;
        chk("w1_run_valid", 64'(bus1.out_valid), 64'd0);
        chk("w1_run_busy", 64'(bus1.busy), 64'd1);
        tick();
        chk("w1_valid", 64'(bus1.out_valid), 64'd1);
        chk("w1_sum", 64'(bus1.sum), 64'd1);
        chk("w1_co", 64'(bus1.carry_out), 64'd1);
        bus1.out_ready = 1'b1;
        tick();
        chk("w1_drop", 64'(bus1.out_valid), 64'd0);
        for (int i = 0; i < 8; i++) begin
            logic [1:0] r1;
            bus1.op_a = 1'($urandom); bus1.op_b = 1'($urandom); bus1.carry_in = 1'($urandom);
            r1 = {1'b0, bus1.op_a} + {1'b0, bus1.op_b} + {1'b0, bus1.carry_in};
            bus1.in_valid = 1'b1;
            tick();
            bus1.in_valid = 1'b0;
            tick();
            chk("w1_rand_valid", 64'(bus1.out_valid), 64'd1);
            chk("w1_rand_sum", 64'(bus1.sum), 64'(r1[0]));
            chk("w1_rand_co", 64'(bus1.carry_out), 64'(r1[1]));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bit_serial_adder_ctrl.md
Name: bit_serial_adder_ctrl

Overview:
- Sequencer that drives one shared 1-bit full-adder slice over a WIDTH-bit operand pair, one bit per clock, LSB first.
- Sits between a requester (valid/ready operand port) and a consumer (valid/ready result port).
- Trades area for latency: one slice plus shift registers, no WIDTH-bit carry chain.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..64.
- CNT_W, $clog2(WIDTH+1), bit counter width (derived, not overridden).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand pair and carry_in valid.
- in_ready  output  1  block can accept operands this cycle.
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B.
- carry_in  input  1  initial carry.
- out_valid  output  1  sum and carry_out valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, a + b + carry_in mod 2^WIDTH.
- carry_out  output  1  carry out of MSB.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1 (combinational from state), out_valid=0, sum=0, carry_out=0, busy=0, bit counter=0, carry register=0, shift registers=0.
- FSM states are IDLE, RUN and DONE. All outputs derive from registers and state, so there are no combinational input-to-output paths.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture op_a and op_b into shift registers, carry register=carry_in, counter=0, go to RUN.
  - With in_valid=0: stay in IDLE.
- RUN:
  - in_ready=0, and in_valid is ignored.
  - Each edge: the slice computes s=a0^b0^c and co=(a0&b0)|(c&(a0^b0)) from the LSBs of the shift registers and the carry register.
  - s shifts into the MSB of the sum register, which shifts right. The A and B registers shift right. carry register=co. Counter increments.
  - When counter==WIDTH-1 on that edge, go to DONE and load carry_out=co.
- DONE:
  - out_valid=1. sum and carry_out are held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid=0, go to IDLE.
  - sum and carry_out keep their last value after the handshake until the next result is produced.
- Latency: the accept edge E0 takes the block into RUN. DONE and out_valid=1 are reached after edge E0+WIDTH.
- Throughput: at most one operation per WIDTH+2 cycles. There is no overlap between an accepted input and a pending output.
- Arithmetic: sum is exact modulo 2^WIDTH, and carry_out is bit WIDTH of the full sum.
- WIDTH=1: RUN lasts exactly one edge.
- Reset mid-operation (RUN or DONE) abandons the operation. The next cycle is IDLE with in_ready=1, and no partial result is ever flagged valid.
- in_valid and out_ready asserted together in DONE: only out_ready acts, and the new operands are accepted at the earliest on the following edge in IDLE.
- X-safety: op_a and op_b are not sampled outside the IDLE accept edge.

Decomposition:
- Shared package adder_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} ser_state_t;
  - the default width constant ADDER_WIDTH_DEFAULT=8.
- Sub-module full_adder_slice: purely combinational, ports a, b, cin, s, cout. It is instantiated once inside the controller.
- The controller contains only the FSM, counter, shift registers and handshake.

Test Plan:
- Reset, then accept 0x0F+0x01 with cin=0 and out_ready=1 → out_valid rises exactly 8 cycles after the accept edge with sum=0x10, carry_out=0; in_ready stays 0 for 9 cycles.
- 0xFF+0x01 with cin=0 → sum=0x00, carry_out=1. Then 0xFF+0xFF with cin=1 → sum=0xFF, carry_out=1. Then 0x00+0x00 with cin=0 → sum=0x00, carry_out=0.
- Backpressure: 0xA5+0x5A with cin=0 and out_ready=0 for 5 cycles in DONE → sum=0xFF and carry_out=0 held constant, out_valid stays 1. It drops one cycle after out_ready=1.
- in_valid held high with changing op_a during RUN → result unaffected (0x12+0x34 → 0x46). The next operation is accepted only in IDLE.
- Assert rst for one cycle at the 4th RUN cycle → next cycle state is IDLE, in_ready=1, out_valid=0, sum=0. A subsequent 0x01+0x01 gives 0x02.
- WIDTH=1 instance: 1+1 with cin=1 → sum=1, carry_out=1, out_valid 1 cycle after accept.
